// File: rtl/nvdla_csb_responder.sv
// CSB target stand-in: one request at a time against a small local register file, plus a countdown-timer interrupt.
// Latency: read data / non-posted write completion RSP_LATENCY cycles after acceptance; posted writes get no response.
// Backpressure: ready is high only in IDLE; posted writes keep it high so they can be accepted back-to-back.
module nvdla_csb_responder #(
  parameter int unsigned NREGS       = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned RSP_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        csb2nvdla_valid_i,
  output logic        csb2nvdla_ready_o,
  input  logic [15:0] csb2nvdla_addr_i,
  input  logic [31:0] csb2nvdla_wdat_i,
  input  logic        csb2nvdla_write_i,
  input  logic        csb2nvdla_nposted_i,
  output logic        nvdla2csb_valid_o,
  output logic [31:0] nvdla2csb_data_o,
  output logic        nvdla2csb_wr_complete_o,
  output logic        dla_intr_o
);

  localparam int unsigned NSCR       = NREGS - 2;
  localparam logic [15:0] TIMER_IDX  = 16'(NREGS - 2);
  localparam logic [15:0] STATUS_IDX = 16'(NREGS - 1);
  // Counter only ever holds RSP_LATENCY-1 down to 1.
  localparam int unsigned CNTW       = (RSP_LATENCY < 2) ? 1 : $clog2(RSP_LATENCY);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(RSP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [15:0]     idx_q;
  logic            write_q;
  logic [31:0]     scratch_q [NSCR];
  logic [31:0]     timer_q;
  logic            status_q;
  logic            rsp_valid_q, rsp_wrc_q;
  logic [31:0]     rsp_data_q;

  logic        accept, wr_en, timer_wr, timer_expire, status_clr, to_resp, rsp_is_write;
  logic [15:0] acc_idx, sel_idx;
  logic [31:0] rdata;

  assign csb2nvdla_ready_o = (state_q == IDLE);
  assign accept   = csb2nvdla_valid_i & csb2nvdla_ready_o;
  // 16-bit wrap: addresses below BASE_ADDR land far out of range.
  assign acc_idx  = csb2nvdla_addr_i - BASE_ADDR;
  assign wr_en    = accept & csb2nvdla_write_i;
  assign timer_wr = wr_en && (acc_idx == TIMER_IDX);
  assign status_clr   = wr_en && (acc_idx == STATUS_IDX) && csb2nvdla_wdat_i[0];
  assign timer_expire = !timer_wr && (timer_q == 32'd1);

  // With RSP_LATENCY=1 the response is sampled in the accept cycle, so use the live request.
  assign sel_idx      = (state_q == IDLE) ? acc_idx : idx_q;
  assign rsp_is_write = (state_q == IDLE) ? csb2nvdla_write_i : write_q;

  assign nvdla2csb_valid_o       = rsp_valid_q;
  assign nvdla2csb_wr_complete_o = rsp_wrc_q;
  assign nvdla2csb_data_o        = rsp_data_q;
  assign dla_intr_o              = status_q;

  // Read mux over scratch, TIMER and STATUS; anything else reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSCR; i++) begin
      if (sel_idx == 16'(i)) rdata = scratch_q[i];
    end
    if (sel_idx == TIMER_IDX)  rdata = timer_q;
    if (sel_idx == STATUS_IDX) rdata = {31'b0, status_q};
  end

  // Next-state logic: count down the remaining latency, flag the cycle that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && (!csb2nvdla_write_i || csb2nvdla_nposted_i)) begin
          if (RSP_LATENCY == 1) begin
            state_d = RESP;
            to_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = RESP;
          to_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, delay counter and captured request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= acc_idx;
        write_q <= csb2nvdla_write_i;
      end
    end
  end

  // Response pulses and held read data, launched on the transition into RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_wrc_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (clear_i) begin
      rsp_valid_q <= 1'b0;
      rsp_wrc_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= to_resp & !rsp_is_write;
      rsp_wrc_q   <= to_resp & rsp_is_write;
      if (to_resp && !rsp_is_write) rsp_data_q <= rdata;
    end
  end

  // Scratch registers are written straight from the accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSCR; i++) begin
        if (wr_en && (acc_idx == 16'(i))) scratch_q[i] <= csb2nvdla_wdat_i;
      end
    end
  end

  // Countdown timer: a write reloads (0 cancels), otherwise decrement toward zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (clear_i) begin
      timer_q <= '0;
    end else if (timer_wr) begin
      timer_q <= csb2nvdla_wdat_i;
    end else if (timer_q != 32'd0) begin
      timer_q <= timer_q - 32'd1;
    end
  end

  // Interrupt pending bit: set on timer 1->0, write-1-to-clear, set wins a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= 1'b0;
    end else if (clear_i) begin
      status_q <= 1'b0;
    end else begin
      status_q <= timer_expire | (status_q & ~status_clr);
    end
  end

endmodule

// File: tb/tb_nvdla_csb_responder.sv
// Directed bench for nvdla_csb_responder: scoreboard of expected responses checked by an independent monitor.
module tb_nvdla_csb_responder;
  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [15:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        write = 1'b0;
  logic        nposted = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_wrc;
  logic        intr;

  nvdla_csb_responder #(.NREGS(16), .BASE_ADDR(16'h0000), .RSP_LATENCY(LAT)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .clear_i                 (clear_i),
    .csb2nvdla_valid_i       (valid),
    .csb2nvdla_ready_o       (ready),
    .csb2nvdla_addr_i        (addr),
    .csb2nvdla_wdat_i        (wdat),
    .csb2nvdla_write_i       (write),
    .csb2nvdla_nposted_i     (nposted),
    .nvdla2csb_valid_o       (rsp_valid),
    .nvdla2csb_data_o        (rsp_data),
    .nvdla2csb_wr_complete_o (rsp_wrc),
    .dla_intr_o              (intr)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int t, t0, t2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response pulse appears.
  exp_t e;
  always @(negedge clk_i) begin
    if (rsp_valid && rsp_wrc) begin
      compared++;
      mismatched++;
      $display("FAIL both_pulses: valid and wr_complete high together at cycle %0d", cyc);
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_rsp: no response pulse, expected at cycle %0d wr=%0b data=%h", e.cyc, e.wr, e.data);
    end
    if (rsp_valid || rsp_wrc) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: cycle %0d valid=%0b wrc=%0b data=%h, expected none", cyc, rsp_valid, rsp_wrc, rsp_data);
      end else begin
        e = q.pop_front();
        compared++;
        if (e.cyc != cyc || e.wr != rsp_wrc || (!e.wr && rsp_data !== e.data)) begin
          mismatched++;
          $display("FAIL rsp: got cycle %0d wrc=%0b data=%h, expected cycle %0d wrc=%0b data=%h",
                   cyc, rsp_wrc, rsp_data, e.cyc, e.wr, e.data);
        end
      end
    end
  end

  // Drive one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic w, input logic n,
                       input bit expect_rsp, input logic [31:0] exp_data, output int t_acc);
    int   budget;
    exp_t x;
    budget = 0;
    valid = 1'b1; addr = a; wdat = d; write = w; nposted = n;
    while (!ready && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: ready=%0b after %0d cycles, expected 1", ready, budget);
    end
    t_acc = cyc;
    if (expect_rsp) begin
      x.cyc = cyc + LAT; x.wr = w; x.data = exp_data;
      q.push_back(x);
    end
    @(negedge clk_i);
    valid = 1'b0;
  endtask

  task automatic wr_p(input logic [15:0] a, input logic [31:0] d, output int t_acc);
    issue(a, d, 1'b1, 1'b0, 1'b0, 32'h0, t_acc);
  endtask
  task automatic wr_np(input logic [15:0] a, input logic [31:0] d, output int t_acc);
    issue(a, d, 1'b1, 1'b1, 1'b1, 32'h0, t_acc);
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] exp, output int t_acc);
    issue(a, 32'h0, 1'b0, 1'b0, 1'b1, exp, t_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_wrc", rsp_wrc, 0);
    chk("rst_intr", intr, 0);
    chk("rst_data", rsp_data, 0);

    // Non-posted write, then read-back with exact latency and ready profile.
    wr_np(16'd3, 32'hCAFE0001, t);
    rd(16'd3, 32'hCAFE0001, t);
    chk("rd_ready_t1", ready, 0);
    @(negedge clk_i);
    chk("rd_ready_t2", ready, 0);
    @(negedge clk_i);
    chk("rd_ready_t3", ready, 1);
    chk("data_held", rsp_data, 32'hCAFE0001);

    // Posted back-to-back writes.
    wr_p(16'd0, 32'd1, t0);
    wr_p(16'd1, 32'd2, t);
    wr_p(16'd2, 32'd3, t2);
    chk("posted_b2b", t2 - t0, 2);
    chk("posted_ready", ready, 1);
    rd(16'd0, 32'd1, t);
    rd(16'd1, 32'd2, t);
    rd(16'd2, 32'd3, t);

    // Out-of-range accesses, including wrap below BASE_ADDR.
    rd(16'h0010, 32'h0, t);
    wr_np(16'h0010, 32'hDEADBEEF, t);
    rd(16'd0, 32'd1, t);
    rd(16'hFFFF, 32'h0, t);

    // Timer expiry raises the interrupt N+1 cycles after the write.
    wr_p(16'd14, 32'd5, t0);
    while (cyc < t0 + 5) @(negedge clk_i);
    chk("intr_before", intr, 0);
    @(negedge clk_i);
    chk("intr_rise", intr, 1);
    rd(16'd14, 32'd0, t);
    rd(16'd15, 32'd1, t);
    wr_p(16'd15, 32'd1, t);
    chk("intr_w1c", intr, 0);
    rd(16'd15, 32'd0, t);

    // Mid-count read, then cancel: no interrupt may follow.
    wr_p(16'd14, 32'd100, t);
    rd(16'd14, 32'd99, t);
    wr_p(16'd14, 32'd0, t);
    repeat (120) @(negedge clk_i);
    chk("cancel_intr", intr, 0);
    rd(16'd15, 32'd0, t);

    // Expiry and W1C in the same cycle: set wins.
    wr_p(16'd14, 32'd2, t);
    wr_p(16'd5, 32'd7, t);
    wr_p(16'd15, 32'd1, t);
    chk("collide_intr", intr, 1);
    rd(16'd15, 32'd1, t);
    rd(16'd5, 32'd7, t);
    wr_p(16'd15, 32'd1, t);
    chk("collide_clear", intr, 0);

    // Reset while a read is waiting: response dropped, registers zeroed.
    issue(16'd3, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, t);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rstwait_ready", ready, 1);
    repeat (4) @(negedge clk_i);
    rd(16'd3, 32'h0, t);
    rd(16'd0, 32'h0, t);
    rd(16'd5, 32'h0, t);

    // Synchronous clear.
    wr_p(16'd1, 32'h55, t);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clear_ready", ready, 1);
    rd(16'd1, 32'h0, t);

    repeat (5) @(negedge clk_i);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nvdla_csb_responder.md
Name: nvdla_csb_responder

Overview:
- CSB target model: the responder end of the NVDLA CSB (csb2nvdla / nvdla2csb) interface that the HWPE CSB master engine and its FSM drive.
- Accepts one request at a time and services it against a small local register file.
- Returns read data, or a write-complete pulse for non-posted writes, after a fixed latency.
- Raises a level interrupt from a programmable countdown timer.
- Used as the NVDLA stand-in in HWPE-level benches and as the loopback target in FPGA bring-up builds.

Parameters:
- NREGS, 16: number of 32-bit registers; must be at least 4.
- BASE_ADDR, 16'h0000: CSB word address of register index 0.
- RSP_LATENCY, 2: cycles from request acceptance to response; must be at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; same effect as reset
- csb2nvdla_valid_i  in  1  request valid
- csb2nvdla_ready_o  out  1  request ready
- csb2nvdla_addr_i  in  16  word address
- csb2nvdla_wdat_i  in  32  write data
- csb2nvdla_write_i  in  1  1 = write, 0 = read
- csb2nvdla_nposted_i  in  1  write requires completion response
- nvdla2csb_valid_o  out  1  read-data valid pulse
- nvdla2csb_data_o  out  32  read data
- nvdla2csb_wr_complete_o  out  1  non-posted write completion pulse
- dla_intr_o  out  1  level interrupt

Behaviour:
- Clocking and reset: one clock, clk_i. rst_ni is asynchronous and active-low. clear_i is synchronous and has the same effect as reset.
- Values after reset or clear:
  - ready = 1; nvdla2csb_valid, wr_complete and dla_intr = 0; data = 0.
  - All registers = 0, delay counter = 0, timer = 0, state = IDLE.
- Register map (idx = addr - BASE_ADDR; valid for 0 <= idx < NREGS):
  - idx 0 .. NREGS-3: scratch, read/write.
  - idx NREGS-2: TIMER. A write loads the countdown; a read returns the current count.
  - idx NREGS-1: STATUS. Bit0 = interrupt pending, write-1-to-clear. Bits 31:1 read as 0.
- Out-of-range addresses: reads return 32'h0; writes are dropped. Response timing is identical to in-range accesses.
- Handshake:
  - csb2nvdla_ready_o = 1 only in IDLE. Acceptance = valid & ready at cycle T.
  - Address, write, nposted and wdat are captured at T; the inputs are don't-care afterwards.
  - Writes update the register at T+1, independent of the response path.
- State machine:
  - IDLE: on acceptance:
    - read, or write with nposted = 1 -> WAIT, delay counter = RSP_LATENCY-1.
    - posted write -> IDLE; ready stays 1 and back-to-back accepts are allowed.
  - WAIT: counter decrements each cycle. When the counter is 0 -> RESP. With RSP_LATENCY = 1, WAIT lasts 0 cycles (go straight to RESP).
  - RESP: for exactly one cycle, at T+RSP_LATENCY:
    - read: nvdla2csb_valid_o = 1 and data = register value sampled at T+RSP_LATENCY-1.
    - non-posted write: wr_complete_o = 1.
    - Next state is IDLE, with ready = 1 in the following cycle.
- Response outputs: data is held at its last value outside valid pulses. valid and wr_complete are never high together.
- Timer:
  - Writing N to TIMER loads timer = N. If timer != 0, it decrements by 1 each cycle.
  - The transition 1 -> 0 sets STATUS bit0.
  - Writing 0 cancels without setting. Rewriting while counting reloads.
- Interrupt: dla_intr_o = STATUS bit0, registered. If set and W1C clear occur in the same cycle, set wins.
- Widths: the idx computation uses 16-bit unsigned arithmetic. An address below BASE_ADDR wraps to a large value and is therefore out of range.
- Reset mid-transaction: any outstanding response is dropped; no valid or wr_complete pulse follows.

Test Plan:
- Read latency, RSP_LATENCY=2: write 32'hCAFE0001 to idx 3 with nposted=1, accepted at T -> wr_complete at T+2. Then read idx 3, accepted at T' -> valid=1 with data 32'hCAFE0001 at exactly T'+2; ready=0 during T'+1..T'+2.
- Posted writes: three back-to-back posted writes to idx 0,1,2 (values 1,2,3) -> ready stays 1 throughout and no wr_complete pulses. Subsequent reads return 1, 2 and 3.
- Out of range, NREGS=16: read addr 16'h0010 -> data 0 after 2 cycles. Non-posted write to addr 16'h0010 -> wr_complete after 2 cycles; scratch registers unchanged.
- Interrupt:
  - Write TIMER=5 at T -> dla_intr_o rises at T+6 and TIMER reads 0.
  - Write STATUS=1 -> intr falls the next cycle.
  - Write TIMER=0 while counting -> no interrupt.
- Set/clear collision: arrange for the timer to expire in the same cycle as a W1C write to STATUS -> STATUS bit0 remains 1.
- Reset during WAIT: read accepted, then rst_ni=0 for 1 cycle -> no valid pulse; ready=1 after release; register file zeroed.
